// File: rtl/keypad_hex_entry_if.sv
// Keypad entry <-> CPU MMIO bundle: key events, assembled 32-bit word, commit/clear/ack pulses.
// Latency: none (wires only); master = keypad_hex_entry, slave = CPU / display side.
// Backpressure: entry_ready stays high until the slave pulses entry_ack (or clear_req).
interface keypad_hex_entry_if;
    logic        commit_req;   // slave -> master: latch entry for the CPU
    logic        clear_req;    // slave -> master: erase entry
    logic        entry_ack;    // slave -> master: committed word consumed
    logic [3:0]  key_code;     // master -> slave: last accepted key nibble
    logic        key_valid;    // master -> slave: one-cycle pulse per accepted key
    logic [31:0] entry_data;   // master -> slave: assembled word, newest nibble in [3:0]
    logic [3:0]  digit_cnt;    // master -> slave: nibbles entered, saturates at 8
    logic        entry_ready;  // master -> slave: word committed, awaiting ack

    modport master (
        input  commit_req, clear_req, entry_ack,
        output key_code, key_valid, entry_data, digit_cnt, entry_ready
    );

    modport slave (
        output commit_req, clear_req, entry_ack,
        input  key_code, key_valid, entry_data, digit_cnt, entry_ready
    );
endinterface

// File: rtl/keypad_hex_entry.sv
// 4x4 active-low keypad scanner + debouncer assembling hex nibbles into a 32-bit MMIO entry word.
// Latency: key_valid one cycle after the DEBOUNCE_SCANS-th low sample; entry updates one cycle later.
// Backpressure: while entry_ready is high the word is frozen until entry_ack/clear_req; keys still pulse.
// Ports: clk, rst_n (async active-low), row_in (async rows, active-low), col_out (one-hot-low drive),
//        bus (keypad_hex_entry_if.master: commit/clear/ack in, key/entry status out).
// Optional: define KEYPAD_AUTOREPEAT_EN to re-issue key_valid every REPEAT_SCANS held samples.
module keypad_hex_entry #(
    parameter int SCAN_DIV       = 50000,  // clk cycles per column step, must be >= 3
    parameter int DEBOUNCE_SCANS = 4,      // must be >= 2
    parameter int REPEAT_SCANS   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         row_in,
    output logic [3:0]         col_out,
    keypad_hex_entry_if.master bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
`endif

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_s1, row_s2;
    logic [DIV_W-1:0]  step_q;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;       // press matches in DEBOUNCE, release matches in HOLD
    logic              kv_q, kv_d;
    logic [3:0]        kc_q, kc_d;
    logic [31:0]       data_q;
    logic [3:0]        dig_q;
    logic              rdy_q;
    logic              sample;
    logic              row_low;
    logic              any_low;
    logic [1:0]        low_row;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0]  rep_q, rep_d;
`endif

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
        endcase
    endfunction

    // Sync flops reset to "all released" so the first scan never sees phantom presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign sample  = (step_q == DIV_W'(SCAN_DIV - 1));
    assign row_low = ~row_s2[row_q];
    assign any_low = ~&row_s2;
    assign col_out = ~(4'b0001 << col_q);

    // Lowest-index low row wins when several rows are pressed in one column.
    always_comb begin
        low_row = 2'd3;
        if (!row_s2[2]) low_row = 2'd2;
        if (!row_s2[1]) low_row = 2'd1;
        if (!row_s2[0]) low_row = 2'd0;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        kv_d    = 1'b0;
        kc_d    = kc_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_d   = low_row;
                        cnt_d   = DB_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_low) begin
                        cnt_d = cnt_q + DB_W'(1);
                        if (cnt_q + DB_W'(1) == DB_W'(DEBOUNCE_SCANS)) begin
                            kv_d    = 1'b1;
                            kc_d    = key_map(row_q, col_q);
                            cnt_d   = '0;
                            state_d = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    if (row_low) begin
                        cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_q + REP_W'(1) == REP_W'(REPEAT_SCANS)) begin
                            kv_d  = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d = '0;
`endif
                        if (cnt_q + DB_W'(1) == DB_W'(DEBOUNCE_SCANS)) begin
                            cnt_d   = '0;
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            step_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            kv_q    <= 1'b0;
            kc_q    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= sample ? '0 : step_q + DIV_W'(1);
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            kv_q    <= kv_d;
            kc_q    <= kc_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Entry word: clear/ack beats everything; key shift and commit only while not committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dig_q  <= '0;
            rdy_q  <= 1'b0;
        end else if (bus.clear_req || bus.entry_ack) begin
            data_q <= '0;
            dig_q  <= '0;
            rdy_q  <= 1'b0;
        end else if (!rdy_q) begin
            if (kv_q) begin
                data_q <= {data_q[27:0], kc_q};
                if (dig_q != 4'd8) dig_q <= dig_q + 4'd1;
            end
            if (bus.commit_req) rdy_q <= 1'b1;
        end
    end

    assign bus.key_code    = kc_q;
    assign bus.key_valid   = kv_q;
    assign bus.entry_data  = data_q;
    assign bus.digit_cnt   = dig_q;
    assign bus.entry_ready = rdy_q;
endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: physical keypad model + behavioural scoreboard checked every cycle.
// Latency: model compares at each negedge, then advances one clock using the inputs the DUT will see.
// Backpressure: CPU commit/clear/ack pulses driven directly and randomly.
module tb_keypad_hex_entry;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;
    localparam int REP      = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       pressed = 1'b0;
    int         pr = 0;
    int         pc = 0;

    keypad_hex_entry_if bus();

    keypad_hex_entry #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .bus(bus)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed switch shorts its row to its column while that column is driven low.
    always_comb begin
        row_in = 4'hF;
        if (pressed && col_out[pc] == 1'b0) row_in[pr] = 1'b0;
    end

    // Key legend laid out row-major as printed on the keypad.
    logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    int n_checks = 0;
    int n_pass   = 0;
    int kv_total = 0;

    // Behavioural model state
    int         m_step, m_col, m_row, m_run, m_rep, m_dig;
    bit         m_locked, m_fired, m_kv, m_rdy;
    logic [3:0] m_kc, s1, s2;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_step = 0; m_col = 0; m_row = 0; m_run = 0; m_rep = 0; m_dig = 0;
        m_locked = 0; m_fired = 0; m_kv = 0; m_rdy = 0;
        m_kc = 4'h0; m_data = 32'h0; s1 = 4'hF; s2 = 4'hF;
    endtask

    task automatic model_compare();
        logic [3:0]  ecol;
        logic [45:0] act, exp;
        ecol = ~(4'b0001 << m_col);
        act = {col_out, bus.key_valid, bus.key_code, bus.entry_data, bus.digit_cnt, bus.entry_ready};
        exp = {ecol, m_kv, m_kc, m_data, 4'(m_dig), m_rdy};
        check("cycle_outputs", 64'(act), 64'(exp));
    endtask

    task automatic model_advance();
        bit nkv;
        int lr;
        nkv = 0;
        // entry word reacts to the key event already on the outputs
        if (bus.clear_req || bus.entry_ack) begin
            m_data = 0; m_dig = 0; m_rdy = 0;
        end else if (!m_rdy) begin
            if (m_kv) begin
                m_data = {m_data[27:0], m_kc};
                m_dig  = (m_dig < 8) ? m_dig + 1 : 8;
            end
            if (bus.commit_req) m_rdy = 1;
        end
        if (m_step == SCAN_DIV - 1) begin
            if (!m_locked) begin
                lr = -1;
                for (int r = 3; r >= 0; r--) if (!s2[r]) lr = r;
                if (lr >= 0) begin
                    m_locked = 1; m_fired = 0; m_row = lr; m_run = 1;
                end else m_col = (m_col + 1) % 4;
            end else if (!m_fired) begin
                if (!s2[m_row]) begin
                    m_run++;
                    if (m_run == DB) begin
                        nkv = 1; m_kc = legend[m_row * 4 + m_col];
                        m_fired = 1; m_run = 0; m_rep = 0;
                    end
                end else begin
                    m_locked = 0; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (!s2[m_row]) begin
                    m_run = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_rep++;
                    if (m_rep == REP) begin nkv = 1; m_rep = 0; end
`endif
                end else begin
                    m_run++; m_rep = 0;
                    if (m_run == DB) begin
                        m_locked = 0; m_col = (m_col + 1) % 4;
                    end
                end
            end
        end
        m_kv   = nkv;
        s2     = s1;
        s1     = row_in;
        m_step = (m_step + 1) % SCAN_DIV;
    endtask

    // One clock: compare + advance at negedge, return just after the next posedge.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
            model_compare();
        end else begin
            model_compare();
            if (bus.key_valid) kv_total++;
            model_advance();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int which);
        if (which == 0) bus.commit_req = 1'b1;
        if (which == 1) bus.clear_req  = 1'b1;
        if (which == 2) bus.entry_ack  = 1'b1;
        tick();
        bus.commit_req = 1'b0; bus.clear_req = 1'b0; bus.entry_ack = 1'b0;
    endtask

    task automatic wait_kv(input int lim);
        int k;
        k = 0;
        while (!bus.key_valid && k < lim) begin tick(); k++; end
        check("key_valid_seen", 64'(bus.key_valid), 64'd1);
    endtask

    task automatic wait_col(input int c);
        int k;
        logic [3:0] want;
        want = ~(4'b0001 << c);
        k = 0;
        while (col_out !== want && k < 64) begin tick(); k++; end
        check("col_reached", 64'(col_out), 64'(want));
    endtask

    // Press until accepted, then release and let the scanner resume.
    task automatic press_one(input int r, input int c);
        pr = r; pc = c; pressed = 1'b1;
        wait_kv(80);
        pressed = 1'b0;
        repeat (16) tick();
    endtask

    task automatic rand_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            bus.commit_req = ($urandom_range(15) == 0);
            bus.clear_req  = ($urandom_range(39) == 0);
            bus.entry_ack  = ($urandom_range(29) == 0);
            tick();
        end
        bus.commit_req = 1'b0; bus.clear_req = 1'b0; bus.entry_ack = 1'b0;
    endtask

    initial begin
        int base;
        bus.commit_req = 1'b0; bus.clear_req = 1'b0; bus.entry_ack = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_col", 64'(col_out), 64'h E);
        check("reset_entry", 64'({bus.key_valid, bus.key_code, bus.entry_data, bus.digit_cnt, bus.entry_ready}), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // idle scan: one column step every SCAN_DIV clocks
        repeat (4) tick();
        check("idle_col1", 64'(col_out), 64'h D);
        repeat (4) tick();
        check("idle_col2", 64'(col_out), 64'h B);
        repeat (12) tick();

        // key 6 held for 20 samples
        base = kv_total;
        wait_col(2);
        pr = 1; pc = 2; pressed = 1'b1;
        repeat (40) tick();
        check("held_col_frozen", 64'(col_out), 64'h B);
        repeat (40) tick();
        pressed = 1'b0;
        wait_col(3);
        check("key6_code", 64'(bus.key_code), 64'h6);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("key6_pulses", 64'(kv_total - base), 64'd1);
        check("key6_entry", 64'({bus.entry_data, bus.digit_cnt}), {28'h0, 32'h6, 4'd1});
`endif

        // single-sample glitch on row1
        repeat (8) tick();
        base = kv_total;
        wait_col(1);
        pr = 1; pc = 1; pressed = 1'b1;
        repeat (4) tick();
        pressed = 1'b0;
        repeat (30) tick();
        check("glitch_no_key", 64'(kv_total - base), 64'd0);

        // nine digits, oldest shifted out
        pulse(1);
        for (int k = 0; k < 9; k++) press_one(k / 3, k % 3);
        check("nine_digits", 64'({bus.entry_data, bus.digit_cnt}), {28'h0, 32'h23456789, 4'd8});
        pulse(0);
        check("commit_ready", 64'(bus.entry_ready), 64'd1);
        press_one(0, 3);
        check("frozen_code", 64'(bus.key_code), 64'hA);
        check("frozen_entry", 64'(bus.entry_data), 64'h23456789);
        pulse(2);
        check("ack_clears", 64'({bus.entry_data, bus.entry_ready}), 64'd0);

        // commit coincident with key_valid includes the nibble
        pr = 1; pc = 1; pressed = 1'b1;
        wait_kv(80);
        pulse(0);
        pressed = 1'b0;
        check("commit_with_key", 64'({bus.entry_data, bus.entry_ready}), {31'h0, 32'h5, 1'b1});
        repeat (16) tick();
        pulse(2);
        // clear coincident with key_valid drops the key
        pr = 2; pc = 0; pressed = 1'b1;
        wait_kv(80);
        pulse(1);
        pressed = 1'b0;
        check("clear_with_key", 64'({bus.entry_data, bus.digit_cnt}), 64'd0);
        repeat (16) tick();

        // key 0 held: auto-repeat every REP samples when enabled
        base = kv_total;
        pr = 3; pc = 1; pressed = 1'b1;
        wait_kv(80);
        repeat (28) tick();
        pressed = 1'b0;
        repeat (20) tick();
`ifdef KEYPAD_AUTOREPEAT_EN
        check("repeat_pulses", 64'(kv_total - base), 64'd3);
        check("repeat_entry", 64'({bus.entry_data, bus.digit_cnt}), {28'h0, 32'h0, 4'd3});
`else
        check("norepeat_pulses", 64'(kv_total - base), 64'd1);
        check("norepeat_entry", 64'({bus.entry_data, bus.digit_cnt}), {28'h0, 32'h0, 4'd1});
`endif

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            pr = $urandom_range(3); pc = $urandom_range(3); pressed = 1'b1;
            rand_ticks($urandom_range(70, 3));
            pressed = 1'b0;
            rand_ticks($urandom_range(40, 3));
        end
        pulse(1);
        press_one(0, 0);

        // reset while debouncing a held key
        pr = 1; pc = 1; pressed = 1'b1;
        wait_col(1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_col", 64'(col_out), 64'h E);
        check("midreset_outs", 64'({bus.key_valid, bus.key_code, bus.entry_data, bus.digit_cnt, bus.entry_ready}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        base = kv_total;
        repeat (8) tick();
        check("no_key_after_reset", 64'(kv_total - base), 64'd0);
        wait_kv(40);
        check("key_after_reset", 64'(bus.key_code), 64'h5);
        pressed = 1'b0;
        repeat (16) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
